// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller for a direct-mapped write-back data cache.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module cache_ctrl_fsm #(
    parameter  int BEATS = 4,
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic          hit,
    input  logic          dirty,
    input  logic          mem_ready,
    output logic          stall,
    output logic          replace_tag,
    output logic          valid_in,
    output logic          dirty_in,
    output logic          data_we,
    output logic          data_sel,
    output logic          mem_rd_req,
    output logic          mem_wr_req,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt,
`endif
    output logic [CW-1:0] beat_cnt
);

    // state      | meaning
    // IDLE       | serve hits combinationally, detect misses
    // WRITE_BACK | stream the dirty victim line out to memory
    // ALLOCATE   | fill the line from memory, write tag on last beat
    // UPDATE     | one bubble so the held request re-evaluates as a hit
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2,
        UPDATE     = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_beat;
    logic [CW-1:0] w_beat_nxt;
    logic          w_req;
    logic          w_last;

    assign w_req    = cpu_rd | cpu_wr;
    assign w_last   = (r_beat == LAST_BEAT);
    assign beat_cnt = r_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        stall       = 1'b0;
        replace_tag = 1'b0;
        valid_in    = 1'b0;
        dirty_in    = 1'b0;
        data_we     = 1'b0;
        data_sel    = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (hit) begin
                        // a store wins when both requests are high
                        if (cpu_wr) begin
                            data_we     = 1'b1;
                            replace_tag = 1'b1;
                            valid_in    = 1'b1;
                            dirty_in    = 1'b1;
                        end
                    end else begin
                        stall       = 1'b1;
                        w_beat_nxt  = '0;
                        w_state_nxt = dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                stall      = 1'b1;
                mem_wr_req = 1'b1;
                if (mem_ready) begin
                    if (w_last) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = ALLOCATE;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            ALLOCATE: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    data_we  = 1'b1;
                    data_sel = 1'b1;
                    if (w_last) begin
                        replace_tag = 1'b1;
                        valid_in    = 1'b1;
                        w_beat_nxt  = '0;
                        w_state_nxt = UPDATE;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            UPDATE: begin
                stall       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // IDLE hit path is combinational, so silence it while reset is held
        if (!rst_n) begin
            stall       = 1'b0;
            replace_tag = 1'b0;
            valid_in    = 1'b0;
            dirty_in    = 1'b0;
            data_we     = 1'b0;
            data_sel    = 1'b0;
            mem_rd_req  = 1'b0;
            mem_wr_req  = 1'b0;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == IDLE && w_req) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Self-checking bench for cache_ctrl_fsm: directed scenarios plus random traffic
// checked against a beats-remaining reference model.
module tb_cache_ctrl_fsm;
    localparam int BEATS = 4;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rd = 1'b0, cpu_wr = 1'b0, hit = 1'b0, dirty = 1'b0, mem_ready = 1'b0;
    logic stall, replace_tag, valid_in, dirty_in, data_we, data_sel, mem_rd_req, mem_wr_req;
    logic [CW-1:0] beat_cnt;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl_fsm #(.BEATS(BEATS)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .hit(hit),
        .dirty(dirty), .mem_ready(mem_ready), .stall(stall), .replace_tag(replace_tag),
        .valid_in(valid_in), .dirty_in(dirty_in), .data_we(data_we), .data_sel(data_sel),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
`ifdef CACHE_PERF_CNT_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: beats left in each transfer phase
    int wb_left = 0;
    int fill_left = 0;
    bit upd = 1'b0;
    int unsigned m_hit = 0;
    int unsigned m_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_busy();
        return (wb_left > 0) || (fill_left > 0) || upd;
    endfunction

    task automatic model_reset();
        wb_left = 0; fill_left = 0; upd = 1'b0; m_hit = 0; m_miss = 0;
    endtask

    // one clock: drive at negedge, check 1ns later, advance the model
    task automatic step(input logic rd, input logic wr, input logic h, input logic d,
                        input logic rdy, output logic st, output logic we);
        logic e_st, e_rt, e_vi, e_di, e_we, e_sel, e_mrd, e_mwr;
        int e_beat;
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; hit = h; dirty = d; mem_ready = rdy;
        #1;
        {e_st, e_rt, e_vi, e_di, e_we, e_sel, e_mrd, e_mwr} = '0;
        e_beat = 0;
`ifdef CACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
`endif
        if (wb_left > 0) begin
            e_st = 1; e_mwr = 1; e_beat = BEATS - wb_left;
            if (rdy) begin
                wb_left--;
                if (wb_left == 0) fill_left = BEATS;
            end
        end else if (fill_left > 0) begin
            e_st = 1; e_mrd = 1; e_beat = BEATS - fill_left;
            if (rdy) begin
                e_we = 1; e_sel = 1;
                if (fill_left == 1) begin e_rt = 1; e_vi = 1; end
                fill_left--;
                if (fill_left == 0) upd = 1'b1;
            end
        end else if (upd) begin
            e_st = 1; upd = 1'b0;
        end else if (rd || wr) begin
            if (h) begin
                m_hit++;
                if (wr) begin e_we = 1; e_rt = 1; e_vi = 1; e_di = 1; end
            end else begin
                e_st = 1; m_miss++;
                if (d) wb_left = BEATS; else fill_left = BEATS;
            end
        end
        check("stall", stall, e_st);
        check("replace_tag", replace_tag, e_rt);
        check("valid_in", valid_in, e_vi);
        check("dirty_in", dirty_in, e_di);
        check("data_we", data_we, e_we);
        check("data_sel", data_sel, e_sel);
        check("mem_rd_req", mem_rd_req, e_mrd);
        check("mem_wr_req", mem_wr_req, e_mwr);
        check("beat_cnt", int'(beat_cnt), e_beat);
        st = stall; we = data_we;
    endtask

    initial begin
        logic st, we;
        int n_stall, n_we, guard;

        // reset with a would-be write hit presented: everything must read 0
        cpu_wr = 1'b1; hit = 1'b1;
        #12;
        check("rst_stall", stall, 0);
        check("rst_replace_tag", replace_tag, 0);
        check("rst_data_we", data_we, 0);
        check("rst_beat_cnt", int'(beat_cnt), 0);
        @(negedge clk); rst_n = 1'b1; cpu_wr = 1'b0; hit = 1'b0;

        // three read hits then one clean read miss, re-evaluated as a hit
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, st, we);
        check("read_hit_no_stall", st, 0);
        n_stall = 0; n_we = 0;
        step(1, 0, 0, 0, 1, st, we);
        n_stall += st; n_we += we;
        guard = 0;
        while (model_busy() && guard < 50) begin
            step(1, 0, 1, 0, 1, st, we);
            n_stall += st; n_we += we; guard++;
        end
        check("clean_miss_guard", guard < 50, 1);
        check("clean_miss_stall_cycles", n_stall, BEATS + 2);
        check("clean_miss_fill_writes", n_we, BEATS);
        step(1, 0, 1, 0, 1, st, we);
        check("post_update_hit", st, 0);
`ifdef CACHE_PERF_CNT_EN
        step(0, 0, 0, 0, 0, st, we);
        check("perf_hit_total", hit_cnt, 4);
        check("perf_miss_total", miss_cnt, 1);
`endif

        // write hit
        step(0, 1, 1, 1, 0, st, we);
        check("write_hit_we", we, 1);

        // dirty write miss with mem_ready toggling
        n_stall = 0;
        step(0, 1, 0, 1, 1, st, we);
        guard = 0;
        while (model_busy() && guard < 100) begin
            step(0, 1, 1, 0, guard[0] ? 1'b0 : 1'b1, st, we);
            n_stall += st; guard++;
        end
        check("dirty_miss_guard", guard < 100, 1);
        step(0, 1, 1, 0, 0, st, we);
        check("dirty_final_write_hit", dirty_in, 1);

        // dirty miss, ready tied high
        n_stall = 0;
        step(1, 1, 0, 1, 1, st, we);
        n_stall += st;
        guard = 0;
        while (model_busy() && guard < 50) begin
            step(1, 1, 1, 1, 1, st, we);
            n_stall += st; guard++;
        end
        check("dirty_miss_stall_cycles", n_stall, 2 * BEATS + 2);

        // reset in the middle of ALLOCATE at beat 2
        step(1, 0, 0, 0, 1, st, we);
        step(1, 0, 0, 0, 1, st, we);
        step(1, 0, 0, 0, 1, st, we);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("pre_rst_beat_cnt", int'(beat_cnt), 2);
        check("pre_rst_mem_rd_req", mem_rd_req, 1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_rd_req", mem_rd_req, 0);
        check("abort_stall", stall, 0);
        check("abort_beat_cnt", int'(beat_cnt), 0);
        check("abort_replace_tag", replace_tag, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_hold_replace_tag", replace_tag, 0);
            check("abort_hold_mem_rd_req", mem_rd_req, 0);
        end
        rst_n = 1'b1; cpu_rd = 1'b0; mem_ready = 1'b0;
        model_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r_rd, r_wr;
            r_rd = ($urandom_range(0, 2) == 0);
            r_wr = ($urandom_range(0, 3) == 0);
            step(r_rd, r_wr, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7, st, we);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
